// File: rtl/dir_cmd_if.sv
// dir_cmd_if: input levels/strobes and registered outputs of the direction command queue
interface dir_cmd_if #(parameter int DEPTH = 4);
    logic                     clear;
    logic                     btn_up, btn_down, btn_left, btn_right;
    logic                     key_valid, key_make;
    logic [8:0]               last_change;
    logic                     onl_up, onl_down, onl_left, onl_right;
    logic                     move_tick;
    logic [1:0]               dir_out;
    logic                     turn_pulse;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport master (
        output clear, btn_up, btn_down, btn_left, btn_right,
        output key_valid, key_make, last_change,
        output onl_up, onl_down, onl_left, onl_right, move_tick,
        input  dir_out, turn_pulse, count, overflow
    );

    modport slave (
        input  clear, btn_up, btn_down, btn_left, btn_right,
        input  key_valid, key_make, last_change,
        input  onl_up, onl_down, onl_left, onl_right, move_tick,
        output dir_out, turn_pulse, count, overflow
    );
endinterface

// File: rtl/dir_cmd_queue.sv
// dir_cmd_queue: merges button/key/online turns, filters null/reversals, releases one per move_tick
module dir_cmd_queue #(parameter int DEPTH = 4) (
    input logic      clk,
    input logic      rst,
    dir_cmd_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    btn_q, onl_q, btn_now, onl_now, btn_rise, onl_rise, key_hot, req;
    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    dir_q, dir_d, cand, ref_dir, head;
    logic          turn_q, turn_d, ovf_q, ovf_d;
    logic          flush, cand_v, accept, empty, full, pop, bypass, push;

    // Direction vectors are indexed by encoding: bit0 up, bit1 down, bit2 left, bit3 right
    always_comb begin
        flush    = rst | bus.clear;
        btn_now  = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
        onl_now  = {bus.onl_right, bus.onl_left, bus.onl_down, bus.onl_up};
        btn_rise = btn_now & ~btn_q;
        onl_rise = onl_now & ~onl_q;
        key_hot  = (bus.key_valid && bus.key_make) ?
                   {bus.last_change == 9'h074, bus.last_change == 9'h06B,
                    bus.last_change == 9'h072, bus.last_change == 9'h075} : 4'b0000;
        req      = (|btn_rise) ? btn_rise : (|key_hot) ? key_hot : onl_rise;
        cand_v   = |req;
        cand     = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
        empty    = count_q == '0;
        full     = count_q == CW'(DEPTH);
        head     = mem_q[rd_q];
        ref_dir  = empty ? dir_q : mem_q[wr_q - AW'(1)];
        accept   = cand_v && cand != ref_dir && cand != (ref_dir ^ 2'b01);
        pop      = !flush && bus.move_tick && !empty;
        bypass   = !flush && bus.move_tick && empty && accept;
        push     = !flush && accept && !bypass && (!full || pop);
        rd_d     = pop ? rd_q + AW'(1) : rd_q;
        wr_d     = push ? wr_q + AW'(1) : wr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        dir_d    = pop ? head : bypass ? cand : dir_q;
        turn_d   = (pop && head != dir_q) || bypass;
        ovf_d    = ovf_q || (accept && full && !pop);
    end

    // Previous-sample registers keep running through clear so held levels do not retrigger
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= '0;
            onl_q <= '0;
        end else begin
            btn_q <= btn_now;
            onl_q <= onl_now;
        end
    end

    // FIFO storage; only written by an accepted, non-bypassed push
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= cand;
    end

    // Pointers, occupancy and registered outputs
    always_ff @(posedge clk) begin
        if (flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            dir_q   <= 2'd3;
            turn_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            turn_q  <= turn_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.dir_out    = dir_q;
    assign bus.turn_pulse = turn_q;
    assign bus.count      = count_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_dir_cmd_queue.sv
// tb_dir_cmd_queue: directed stimulus with a queue-based reference model checked every cycle
module tb_dir_cmd_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dir_cmd_if #(.DEPTH(DEPTH)) bus ();
    dir_cmd_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int mq[$];
    int mdir = 3;
    bit mpulse = 0;
    bit movf = 0;
    bit [3:0] pb = 0, po = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit [3:0] b, o, br, orr;
        int cand, r, old;
        b = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
        o = {bus.onl_right, bus.onl_left, bus.onl_down, bus.onl_up};
        if (rst) begin
            mq.delete(); mdir = 3; mpulse = 0; movf = 0; pb = 0; po = 0;
            return;
        end
        br = b & ~pb; orr = o & ~po; pb = b; po = o;
        if (bus.clear) begin
            mq.delete(); mdir = 3; mpulse = 0; movf = 0;
            return;
        end
        cand = -1;
        for (int d = 0; d < 4; d++) if (cand < 0 && br[d]) cand = d;
        if (cand < 0 && bus.key_valid && bus.key_make)
            case (bus.last_change)
                9'h075: cand = 0;
                9'h072: cand = 1;
                9'h06B: cand = 2;
                9'h074: cand = 3;
                default: cand = -1;
            endcase
        for (int d = 0; d < 4; d++) if (cand < 0 && orr[d]) cand = d;
        r = (mq.size() > 0) ? mq[$] : mdir;
        if (cand >= 0 && (cand == r || cand == (r ^ 1))) cand = -1;
        mpulse = 0;
        if (bus.move_tick && mq.size() > 0) begin
            old = mdir;
            mdir = mq.pop_front();
            mpulse = mdir != old;
            if (cand >= 0) mq.push_back(cand);
        end else if (bus.move_tick && cand >= 0) begin
            mdir = cand;
            mpulse = 1;
        end else if (cand >= 0) begin
            if (mq.size() < DEPTH) mq.push_back(cand);
            else movf = 1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("dir_out", bus.dir_out, mdir);
            check("turn_pulse", bus.turn_pulse, mpulse);
            check("count", bus.count, mq.size());
            check("overflow", bus.overflow, movf);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [8:0] code, input logic tick);
        bus.key_valid = 1; bus.key_make = 1; bus.last_change = code; bus.move_tick = tick;
        step(1);
        bus.key_valid = 0; bus.move_tick = 0;
    endtask

    task automatic tick();
        bus.move_tick = 1;
        step(1);
        bus.move_tick = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step(1);
        rst = 0;
    endtask

    initial begin
        bus.clear = 0; bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.key_valid = 0; bus.key_make = 0; bus.last_change = 0;
        bus.onl_up = 0; bus.onl_down = 0; bus.onl_left = 0; bus.onl_right = 0; bus.move_tick = 0;
        step(2);
        rst = 0;
        check("rst_dir", bus.dir_out, 3);
        check("rst_count", bus.count, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_pulse", bus.turn_pulse, 0);

        bus.btn_up = 1; step(1);
        check("btn_up_count", bus.count, 1);
        check("btn_up_dir", bus.dir_out, 3);
        bus.btn_up = 0; step(1);
        tick();
        check("pop_dir", bus.dir_out, 0);
        check("pop_pulse", bus.turn_pulse, 1);
        check("pop_count", bus.count, 0);
        step(1);
        check("pulse_one_cycle", bus.turn_pulse, 0);

        do_reset();
        key(9'h06B, 0); key(9'h074, 0); key(9'h075, 0);
        check("filter_count", bus.count, 1);
        tick();
        check("filter_dir", bus.dir_out, 0);

        do_reset();
        key(9'h075, 0); key(9'h06B, 0); key(9'h072, 0); key(9'h074, 0); key(9'h075, 0);
        check("full_count", bus.count, 4);
        check("full_ovf", bus.overflow, 1);
        key(9'h072, 1);
        check("pushpop_full_dir", bus.dir_out, 0);
        check("pushpop_full_count", bus.count, 4);
        tick(); check("drain_dir1", bus.dir_out, 2);
        tick(); check("drain_dir2", bus.dir_out, 1);
        tick(); check("drain_dir3", bus.dir_out, 3);
        tick(); check("drain_dir4", bus.dir_out, 1);
        check("drain_count", bus.count, 0);
        check("ovf_sticky", bus.overflow, 1);
        tick(); check("empty_tick_pulse", bus.turn_pulse, 0);

        do_reset();
        key(9'h075, 1);
        check("bypass_dir", bus.dir_out, 0);
        check("bypass_pulse", bus.turn_pulse, 1);
        check("bypass_count", bus.count, 0);
        bus.btn_left = 1; bus.onl_up = 1; step(1);
        check("prio_count", bus.count, 1);
        bus.btn_left = 0; bus.onl_up = 0; step(1);
        tick();
        check("prio_dir", bus.dir_out, 2);
        key(9'h042, 0);
        check("bad_code_count", bus.count, 0);

        do_reset();
        key(9'h075, 0); key(9'h06B, 0); key(9'h072, 0); key(9'h074, 0); key(9'h075, 0);
        tick();
        check("pre_clear_count", bus.count, 3);
        check("pre_clear_ovf", bus.overflow, 1);
        bus.btn_down = 1; bus.clear = 1; step(1);
        bus.clear = 0;
        check("clear_count", bus.count, 0);
        check("clear_dir", bus.dir_out, 3);
        check("clear_ovf", bus.overflow, 0);
        step(3);
        check("held_no_retrigger", bus.count, 0);
        bus.btn_down = 0;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
